// File: rtl/alu_cmd_issue.sv
// Command issue stage: queues ALU commands in a circular FIFO, presents the head
// to an external combinational ALU and captures the result in a ready/valid register.
module alu_cmd_issue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [2:0]               in_sel,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_sel,
  input  logic [3:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_data,
  output logic [2:0]               res_sel,
  output logic                     res_zero,
  output logic                     res_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [10:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] occ_q, occ_d;
  logic [10:0]     head;
  logic            push, pop, empty;

  logic       res_valid_q;
  logic [3:0] res_data_q;
  logic [2:0] res_sel_q;
  logic       res_zero_q, res_illegal_q;

  // in_ready depends only on registered occupancy, never on res_ready.
  assign in_ready = (occ_q < FullCnt);
  assign empty    = (occ_q == '0);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!res_valid_q || res_ready);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_sel = 3'b000;
    if (!empty) begin
      alu_a   = head[10:7];
      alu_b   = head[6:3];
      alu_sel = head[2:0];
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_sel};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_data_q    <= 4'h0;
      res_sel_q     <= 3'b000;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else if (pop) begin
      res_valid_q   <= 1'b1;
      res_data_q    <= alu_out;
      res_sel_q     <= head[2:0];
      res_zero_q    <= (alu_out == 4'h0);
      res_illegal_q <= (head[2:0] >= 3'b101);
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_sel     = res_sel_q;
  assign res_zero    = res_zero_q;
  assign res_illegal = res_illegal_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: cycle model of occupancy/valid plus a
// result scoreboard filled at command acceptance and drained at result consumption.
module tb_alu_cmd_issue;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b;
  logic [2:0] in_sel;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [2:0] res_sel;
  logic       res_zero, res_illegal;
  logic [2:0] occupancy;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Model state: sb[0] is the result register content whenever m_rv is set.
  logic [8:0] sb[$];
  int         m_occ;
  logic       m_rv;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sel(res_sel), .res_zero(res_zero),
    .res_illegal(res_illegal), .occupancy(occupancy)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      default: return 4'h0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_sel);

  function automatic logic [8:0] exp_entry(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
    logic [3:0] d;
    d = alu_f(a, b, s);
    return {d, s, (d == 4'h0), (s >= 3'b101)};
  endfunction

  // One clock of stimulus; checks the DUT against the model before the edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] s, input logic rr);
    logic push, pop, consume;
    in_valid = v; in_a = a; in_b = b; in_sel = s; res_ready = rr;
    @(negedge clk);
    vectors++;
    if (occupancy !== 3'(m_occ)) begin
      errors++;
      $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, m_occ, $time);
    end
    vectors++;
    if (in_ready !== (m_occ < DEPTH)) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, (m_occ < DEPTH), $time);
    end
    vectors++;
    if (res_valid !== m_rv) begin
      errors++;
      $display("FAIL res_valid: got %b expected %b at %0t", res_valid, m_rv, $time);
    end
    if (m_occ == 0) begin
      vectors++;
      if ({alu_a, alu_b, alu_sel} !== 11'h0) begin
        errors++;
        $display("FAIL alu_idle: got %h expected 0 at %0t", {alu_a, alu_b, alu_sel}, $time);
      end
    end
    if (m_rv) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result: got %h but scoreboard empty at %0t",
                 {res_data, res_sel, res_zero, res_illegal}, $time);
      end else if ({res_data, res_sel, res_zero, res_illegal} !== sb[0]) begin
        errors++;
        $display("FAIL result: got %h expected %h at %0t",
                 {res_data, res_sel, res_zero, res_illegal}, sb[0], $time);
      end
    end
    push    = v && (m_occ < DEPTH);
    pop     = (m_occ != 0) && (!m_rv || rr);
    consume = m_rv && rr;
    if (consume && sb.size() != 0) void'(sb.pop_front());
    if (push) sb.push_back(exp_entry(a, b, s));
    m_occ = m_occ + int'(push) - int'(pop);
    if (pop) m_rv = 1'b1;
    else if (consume) m_rv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 3'b000, rr);
  endtask

  task automatic apply_reset(input logic v, input logic rr);
    rst = 1'b1; in_valid = v; res_ready = rr;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    m_occ = 0;
    m_rv  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && (sb.size() != 0 || m_rv); i++) idle(1, 1'b1);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding", sb.size());
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    vectors++;
    if ({occupancy, res_valid, res_data, res_sel, res_zero, res_illegal, in_ready} !== 14'h1) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0001",
               {occupancy, res_valid, res_data, res_sel, res_zero, res_illegal, in_ready});
    end
  endtask

  task automatic test_add();
    step(1'b1, 4'd3, 4'd4, 3'b000, 1'b1);
    vectors++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_no_bypass: res_valid got %b expected 0", res_valid);
    end
    idle(1, 1'b1);
    vectors++;
    if ({res_valid, res_data, res_zero, res_illegal} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_result: got %b expected 1_0111_0_0",
               {res_valid, res_data, res_zero, res_illegal});
    end
    drain();
  endtask

  task automatic test_sub_not();
    step(1'b1, 4'd5, 4'd5, 3'b001, 1'b1);
    step(1'b1, 4'hF, 4'h0, 3'b100, 1'b1);
    vectors++;
    if ({res_valid, res_data, res_zero, res_sel} !== {1'b1, 4'h0, 1'b1, 3'b001}) begin
      errors++;
      $display("FAIL sub_result: got %b expected 1_0000_1_001",
               {res_valid, res_data, res_zero, res_sel});
    end
    idle(1, 1'b1);
    vectors++;
    if ({res_valid, res_data, res_zero, res_sel} !== {1'b1, 4'h0, 1'b1, 3'b100}) begin
      errors++;
      $display("FAIL not_result: got %b expected 1_0000_1_100",
               {res_valid, res_data, res_zero, res_sel});
    end
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 1), 4'(2 * i), 3'(i % 4), 1'b0);
    vectors++;
    if ({in_ready, occupancy, res_valid} !== {1'b0, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full: got ready=%b occ=%0d rv=%b expected ready=0 occ=4 rv=1",
               in_ready, occupancy, res_valid);
    end
    step(1'b1, 4'hA, 4'hA, 3'b000, 1'b0);
    // Full with a same-cycle pop: the offered command must not be admitted.
    step(1'b1, 4'hB, 4'hB, 3'b000, 1'b1);
    drain();
  endtask

  task automatic test_illegal();
    step(1'b1, 4'd9, 4'd2, 3'b110, 1'b1);
    idle(1, 1'b1);
    vectors++;
    if ({res_valid, res_data, res_illegal, res_zero} !== {1'b1, 4'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal: got %b expected 1_0000_1_1",
               {res_valid, res_data, res_illegal, res_zero});
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 4'd1, 3'b000, 1'b0);
    vectors++;
    if ({occupancy, res_valid} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got occ=%0d rv=%b expected occ=3 rv=1", occupancy, res_valid);
    end
    apply_reset(1'b1, 1'b1);
    vectors++;
    if ({occupancy, res_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got occ=%0d rv=%b rdy=%b expected 0 0 1",
               occupancy, res_valid, in_ready);
    end
    idle(4, 1'b1);
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'(i), 4'(i + 3), 3'(i % 5), 1'b1);
      if (res_valid) seen++;
    end
    vectors++;
    if (seen != 5) begin
      errors++;
      $display("FAIL throughput: got %0d results in 6 cycles expected 5", seen);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 3'($urandom),
           ($urandom_range(0, 2) != 0));
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_sel = 3'b000;
    res_ready = 1'b0;
    m_occ = 0; m_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub_not();
    test_full();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
